// File: rtl/adder_req_issuer_pkg.sv
// Shared types and defaults for the adder request issuer.
package adder_issuer_pkg;
  localparam int DEF_DW      = 1;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;
endpackage

// File: rtl/adder_req_issuer_sync_2ff.sv
// Two-flop synchronizer, reset to zero.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/adder_req_issuer.sv
// Buffers operand pairs and issues them one at a time on the req/busy handshake,
// aborting a request that the consumer never accepts.
module adder_req_issuer
  import adder_issuer_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic             req,
  output logic [DW-1:0]    a,
  output logic [DW-1:0]    b,
  input  logic             busy,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             err_timeout,
  output logic             idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  logic [2*DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  state_t          r_state;
  logic            r_req;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [TW-1:0]   r_tcnt;
  logic [CNT_W-1:0] r_cnt;
  logic            r_err;

  logic w_busy_s;
  logic w_full;
  logic w_empty;
  logic w_push;

  sync_2ff #(.W(1)) u_busy_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (busy),
    .o_q   (w_busy_s)
  );

  // Extra pointer bit separates full from empty once the pointers wrap.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = in_valid && !w_full;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr_ptr <= '0;
    else if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
  end

  // The head entry stays in the FIFO while requested; it leaves on accept or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_tcnt   <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty && !w_busy_s) begin
            r_state    <= REQ;
            r_req      <= 1'b1;
            {r_a, r_b} <= r_mem[r_rd_ptr[AW-1:0]];
            r_tcnt     <= '0;
          end
        end
        REQ: begin
          if (w_busy_s) begin
            r_state  <= WAIT_DONE;
            r_req    <= 1'b0;
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_cnt    <= r_cnt + CNT_W'(1);
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_err    <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!w_busy_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = !w_full;
  assign req         = r_req;
  assign a           = r_a;
  assign b           = r_b;
  assign issued_cnt  = r_cnt;
  assign err_timeout = r_err;
  assign idle        = (r_state == IDLE) && w_empty;
endmodule

// File: tb/tb_adder_req_issuer.sv
// Scoreboard bench: pushes are queued as expected issues, a monitor checks every
// request against the queue, and a consumer model answers requests.
module tb_adder_req_issuer;
  localparam int DW = 1, DEPTH = 4, TIMEOUT = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic in_ready, req, err_timeout, idle;
  logic [DW-1:0] a, b;
  logic [7:0] issued_cnt;
  logic cons_busy = 1'b0, force_busy = 1'b0;
  logic busy;
  assign busy = cons_busy | force_busy;

  adder_req_issuer #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .req(req), .a(a), .b(b), .busy(busy),
    .issued_cnt(issued_cnt), .err_timeout(err_timeout), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; } pair_t;
  pair_t exp_q[$];
  pair_t cur;
  int  outstanding = 0, dur = 0, exp_cnt = 0, n_pushed = 0;
  bit  exp_err = 0;
  logic prev_req = 1'b0;

  // consumer controls and per-transaction record
  bit cons_en = 0, cons_drop = 0, cons_rand = 0;
  int cons_d = 2, cons_h = 5, drop_pct = 0;
  bit tr_acc = 1;
  int tr_d = 0;

  // Monitor / scoreboard: everything observed just after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        outstanding = 0; dur = 0; exp_cnt = 0; exp_err = 0; prev_req = 1'b0;
      end else begin
        if (in_valid && (exp_q.size() + outstanding) < DEPTH) begin
          exp_q.push_back('{in_a, in_b});
          n_pushed++;
        end
        if (req && !prev_req) begin
          chk("req_has_entry", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            outstanding = 1;
            dur = 1;
            chk("issue_a", a, cur.a);
            chk("issue_b", b, cur.b);
          end
        end else if (req && prev_req) begin
          dur++;
          chk("hold_a", a, cur.a);
          chk("hold_b", b, cur.b);
        end else if (!req && prev_req) begin
          outstanding = 0;
          if (tr_acc) begin
            exp_cnt++;
            chk("req_len_accept", dur, tr_d + 3);
          end else begin
            exp_err = 1;
            chk("req_len_timeout", dur, TIMEOUT);
          end
          chk("issued_cnt", issued_cnt, exp_cnt[7:0]);
          chk("err_timeout", err_timeout, exp_err);
        end
        chk("in_ready", in_ready, (exp_q.size() + outstanding) < DEPTH);
        prev_req = req;
      end
    end
  end

  // Consumer: raises busy d cycles after seeing req, holds h cycles, or ignores it.
  initial begin
    forever begin
      @(negedge clk);
      if (cons_en && req && !rst) begin
        int d, h;
        bit drop;
        drop = cons_drop || (cons_rand && ($urandom_range(99, 0) < drop_pct));
        d = cons_rand ? $urandom_range(10, 1) : cons_d;
        h = cons_rand ? $urandom_range(6, 1) : cons_h;
        tr_acc = !drop;
        tr_d = d;
        if (!drop) begin
          repeat (d) @(posedge clk);
          #1 cons_busy = 1'b1;
          repeat (h) @(posedge clk);
          #1 cons_busy = 1'b0;
        end
        for (int n = 0; n < 64 && req; n++) @(negedge clk);
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) (req && $past(req)) |-> ($stable(a) && $stable(b)));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] pa, input logic [DW-1:0] pb);
    in_valid = 1'b1; in_a = pa; in_b = pb;
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    while (idle !== 1'b1 && n < lim) begin cyc(1); n++; end
    chk(nm, idle, 1);
  endtask

  task automatic random_run(input int npush, input int budget);
    int base = n_pushed;
    int n = 0;
    while ((n_pushed - base) < npush && n < budget) begin
      in_valid = ($urandom_range(1, 0) == 1);
      in_a = DW'($urandom);
      in_b = DW'($urandom);
      cyc(1);
      n++;
    end
    in_valid = 1'b0;
    chk("push_budget", (n_pushed - base) == npush, 1);
  endtask

  logic [1:0] fill_v [5];

  initial begin
    fill_v = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
    // reset values
    cyc(1);
    chk("rst_req", req, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_cnt", issued_cnt, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    rst = 1'b0;

    // single transaction
    cons_en = 1; cons_d = 2; cons_h = 5;
    cyc(3);
    push('0, '1);
    chk("single_req_lat0", req, 0);
    cyc(1);
    chk("single_req_lat1", req, 1);
    chk("single_a", a, 0);
    chk("single_b", b, 1);
    wait_idle("single_idle", 100);
    chk("single_cnt", issued_cnt, 1);
    cyc(15);

    // fill and drain with the consumer stalled
    do_reset();
    force_busy = 1'b1;
    cyc(3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = fill_v[i][1]; in_b = fill_v[i][0];
      cyc(1);
      chk("fill_in_ready", in_ready, i < 3);
    end
    in_valid = 1'b0;
    chk("fill_no_req", req, 0);
    force_busy = 1'b0;
    wait_idle("fill_idle", 300);
    chk("fill_cnt", issued_cnt, 4);
    cyc(15);

    // timeout
    do_reset();
    cons_drop = 1;
    cyc(3);
    push('1, '1);
    for (int n = 0; n < 40 && (req || n < 2); n++) cyc(1);
    wait_idle("to_idle", 50);
    chk("to_err", err_timeout, 1);
    chk("to_cnt", issued_cnt, 0);
    cyc(5);
    chk("to_err_sticky", err_timeout, 1);
    chk("to_in_ready", in_ready, 1);
    cons_drop = 0;
    cyc(5);

    // reset in the middle of a request with entries queued
    do_reset();
    cons_en = 0;
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = DW'(i); in_b = DW'(i + 1);
      cyc(1);
    end
    in_valid = 1'b0;
    chk("mid_req_before", req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_idle", idle, 1);
    force_busy = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    push('1, '0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_busy_gate", req, 0);
      cyc(1);
    end
    cons_en = 1;
    force_busy = 1'b0;
    cyc(1);
    chk("mid_gate_k0", req, 0);
    cyc(1);
    chk("mid_gate_k1", req, 0);
    cyc(1);
    chk("mid_gate_k2", req, 1);
    chk("mid_a", a, 1);
    chk("mid_b", b, 0);
    wait_idle("mid_idle", 100);
    chk("mid_cnt", issued_cnt, 1);
    cyc(15);

    // random traffic with some ignored requests
    do_reset();
    cons_rand = 1; drop_pct = 25;
    cyc(3);
    random_run(40, 4000);
    wait_idle("rand_idle", 300);
    cyc(15);

    // counter wrap: 257 accepted transactions
    do_reset();
    drop_pct = 0;
    cyc(3);
    random_run(257, 20000);
    wait_idle("wrap_idle", 300);
    chk("wrap_cnt", issued_cnt, 1);
    chk("wrap_err", err_timeout, 0);
    chk("wrap_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end
endmodule
